// File: rtl/ddr4_v2_2_20_axi_ctrl_lite_master.sv
// ---------------------------------------------------------------------------
// ddr4_v2_2_20_axi_ctrl_lite_master
//
// AXI4-Lite initiator for the DDR4 controller's control-register slave.
// Accepts one register read or write command at a time. It runs the matching
// AXI4-Lite transaction and returns the data and response on a response
// channel. A watchdog bounds each transaction. If the slave never answers,
// the watchdog forces a SLVERR response, drops every AXI valid/ready and
// parks the block in a sticky hung state that only areset leaves.
//
// Handshake rule used on every channel (cmd, rsp, AXI): a transfer happens
// on the rising aclk edge where valid and ready are both high. A valid, once
// raised, stays high with stable payload until that edge. The one exception
// is watchdog recovery, which drops AXI valids without a handshake.
//
// Ports
//   aclk, areset          clock; synchronous active-high reset
//   cmd_*                 command request (valid/ready, write flag, addr,
//                         wdata, wstrb)
//   rsp_*                 response (valid/ready, rdata, resp, timeout flag)
//   hung                  sticky flag, set by a watchdog timeout
//   m_axi_*               AXI4-Lite master interface (AW, W, B, AR, R)
//   dbg_state             current FSM state, for observation only
// ---------------------------------------------------------------------------
module ddr4_v2_2_20_axi_ctrl_lite_master #(
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 255
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      hung,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_RSP     = 3'd5,
        S_HUNG    = 3'd6
    } state_t;

    localparam logic [16:0] TO_LIM = 17'(C_TIMEOUT_CYCLES);

    state_t state_q, state_d;
    logic [15:0] wd_q, wd_d, wd_inc;
    logic        wd_hit;
    logic        timeout_armed;

    logic                      cmd_ready_d;
    logic [C_ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_d;
    logic [C_DATA_WIDTH/8-1:0] wstrb_d;
    logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic                      rsp_valid_d, rsp_timeout_d, hung_d;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata_d;
    logic [1:0]                rsp_resp_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign dbg_state    = state_q;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid  & m_axi_rready;

    // The counter saturates so that it cannot wrap back below the limit.
    assign wd_inc = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    // wd_q counts the busy cycles before the current one. The limit is hit
    // when this cycle is the C_TIMEOUT_CYCLES-th busy cycle. ">=" keeps the
    // check armed after a handshake completed exactly at the limit.
    assign wd_hit = (TO_LIM != 17'd0) && (({1'b0, wd_q} + 17'd1) >= TO_LIM);

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        timeout_armed = 1'b0;
        cmd_ready_d   = cmd_ready;
        awaddr_d      = m_axi_awaddr;
        awvalid_d     = m_axi_awvalid;
        wdata_d       = m_axi_wdata;
        wstrb_d       = m_axi_wstrb;
        wvalid_d      = m_axi_wvalid;
        bready_d      = m_axi_bready;
        araddr_d      = m_axi_araddr;
        arvalid_d     = m_axi_arvalid;
        rready_d      = m_axi_rready;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        hung_d        = hung;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    wd_d        = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_AW_W;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end
                end
            end

            S_WR_AW_W: begin
                wd_d = wd_inc;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // A channel is finished once its valid is low (an earlier
                // handshake) or it handshakes on this edge.
                if ((!m_axi_awvalid || aw_hs) && (!m_axi_wvalid || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end else if (!aw_hs && !w_hs) begin
                    timeout_armed = 1'b1;
                end
            end

            S_WR_B: begin
                wd_d = wd_inc;
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else begin
                    timeout_armed = 1'b1;
                end
            end

            S_RD_AR: begin
                wd_d = wd_inc;
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end else begin
                    timeout_armed = 1'b1;
                end
            end

            S_RD_R: begin
                wd_d = wd_inc;
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_resp_d    = m_axi_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else begin
                    timeout_armed = 1'b1;
                end
            end

            S_RSP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_timeout) begin
                        state_d = S_HUNG;
                    end else begin
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_HUNG: begin
                // Terminal until reset. Late B/R beats are not accepted.
                cmd_ready_d = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog recovery: abandon the transaction by dropping every AXI
        // valid/ready, then report SLVERR with the timeout flag.
        if (timeout_armed && wd_hit) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            hung_d        = 1'b1;
            state_d       = S_RSP;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            cmd_ready     <= 1'b1;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            hung          <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            cmd_ready     <= cmd_ready_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            hung          <= hung_d;
        end
    end

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_ctrl_lite_master.sv
module tb_ddr4_v2_2_20_axi_ctrl_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   cyc = 0;
  initial forever #5 aclk = ~aclk;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // ---------------- DUT signals ----------------
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_timeout, hung;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot, dbg_state;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0, m_axi_rready;

  ddr4_v2_2_20_axi_ctrl_lite_master #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .hung(hung),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];   // {rdata, resp, timeout}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- slave model knobs ----------------
  int   aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic ar_never = 1'b0, r_force = 1'b0;
  logic [1:0]    b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [DW-1:0] r_data_cfg = '0;

  // Slave drives 2 time units after each rising edge from the DUT outputs
  // of the new cycle. A ready/valid rises once the master signal has been
  // high for <delay> earlier cycles.
  initial begin
    int aw_c, w_c, ar_c, b_c, r_c;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    forever begin
      @(posedge aclk);
      #2;
      if (m_axi_awvalid) begin m_axi_awready = (aw_c >= aw_delay); aw_c++; end
      else begin m_axi_awready = 1'b0; aw_c = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_c >= w_delay); w_c++; end
      else begin m_axi_wready = 1'b0; w_c = 0; end
      if (m_axi_arvalid) begin m_axi_arready = !ar_never && (ar_c >= ar_delay); ar_c++; end
      else begin m_axi_arready = 1'b0; ar_c = 0; end
      if (m_axi_bready) begin m_axi_bvalid = (b_c >= b_delay); b_c++; end
      else begin m_axi_bvalid = 1'b0; b_c = 0; end
      if (r_force) m_axi_rvalid = 1'b1;
      else if (m_axi_rready) begin m_axi_rvalid = (r_c >= r_delay); r_c++; end
      else begin m_axi_rvalid = 1'b0; r_c = 0; end
      if (!m_axi_rready) r_c = r_force ? r_c : 0;
      m_axi_bresp = b_resp_cfg;
      m_axi_rresp = r_resp_cfg;
      m_axi_rdata = r_data_cfg;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int aw_hi, w_hi, ar_hi, bready_hi, rready_hi, b_hs, r_hs, cmd_acc;
  int acc_cyc, first_rsp;
  logic rsp_seen;

  task automatic clear_stats();
    aw_hi = 0; w_hi = 0; ar_hi = 0; bready_hi = 0; rready_hi = 0;
    b_hs = 0; r_hs = 0; cmd_acc = 0; acc_cyc = 0; first_rsp = 0; rsp_seen = 1'b0;
  endtask

  initial begin
    logic [34:0] e;
    clear_stats();
    forever begin
      @(negedge aclk);
      if (!areset) begin
        aw_hi     += int'(m_axi_awvalid);
        w_hi      += int'(m_axi_wvalid);
        ar_hi     += int'(m_axi_arvalid);
        bready_hi += int'(m_axi_bready);
        rready_hi += int'(m_axi_rready);
        b_hs      += int'(m_axi_bvalid && m_axi_bready);
        r_hs      += int'(m_axi_rvalid && m_axi_rready);
        if (cmd_valid && cmd_ready) begin acc_cyc = cyc; cmd_acc++; end
        if (rsp_valid) begin
          if (!rsp_seen) begin rsp_seen = 1'b1; first_rsp = cyc; end
          check("cmd_ready_low_during_rsp", cmd_ready, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_rsp_valid", rsp_valid, 0);
          end else begin
            e = rsp_ready ? exp_q.pop_front() : exp_q[0];
            check("rsp_rdata", rsp_rdata, e[34:3]);
            check("rsp_resp", rsp_resp, e[2:1]);
            check("rsp_timeout", rsp_timeout, e[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge. On return the
  // DUT is in the first cycle after the accept edge (T+1).
  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [3:0] strb);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!acc && n < 50) begin
      @(negedge aclk);
      if (cmd_ready) acc = 1'b1;
      n++;
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", acc, 1);
  endtask

  // Holds rsp_ready low for <hold> rsp_valid cycles, then completes the
  // handshake and checks cmd_ready in the cycle after it.
  task automatic wait_rsp(input int hold, input logic exp_ready_after);
    int n, held;
    logic done;
    n = 0; held = 0; done = 1'b0;
    rsp_ready = (hold == 0);
    while (!done && n < 100) begin
      @(negedge aclk);
      n++;
      if (rsp_valid && rsp_ready) done = 1'b1;
      else if (rsp_valid) held++;
      tick();
      if (held >= hold) rsp_ready = 1'b1;
    end
    check("rsp_handshake_seen", done, 1);
    check("cmd_ready_after_rsp", cmd_ready, exp_ready_after);
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_hung", hung, 0);
    check("rst_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    check("rst_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 0);
    check("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    logic saw;

    // reset state
    repeat (3) tick();
    check_reset_vals();
    areset = 1'b0;
    tick();

    // 1: write, always-ready slave, T+3 latency
    clear_stats();
    exp_q.push_back({32'h0000_0000, 2'b00, 1'b0});
    issue(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    check("t1_aw_w_valid_t1", {m_axi_awvalid, m_axi_wvalid, cmd_ready}, 3'b110);
    check("t1_awaddr", m_axi_awaddr, 32'h0000_0010);
    check("t1_wdata", m_axi_wdata, 32'hA5A5_5A5A);
    check("t1_wstrb", m_axi_wstrb, 4'hF);
    wait_rsp(0, 1'b1);
    check("t1_latency", first_rsp - acc_cyc, 3);
    check("t1_aw_cycles", aw_hi, 1);
    check("t1_w_cycles", w_hi, 1);
    check("t1_bready_cycles", bready_hi, 1);

    // 2: awready delayed 4 cycles, wready immediate
    clear_stats();
    aw_delay = 4;
    exp_q.push_back({32'h0000_0000, 2'b00, 1'b0});
    issue(1'b1, 32'h0000_0014, 32'h1234_5678, 4'h3);
    wait_rsp(0, 1'b1);
    aw_delay = 0;
    check("t2_aw_cycles", aw_hi, 5);
    check("t2_w_cycles", w_hi, 1);
    check("t2_b_handshakes", b_hs, 1);
    check("t2_latency", first_rsp - acc_cyc, 7);

    // 3a: read with rvalid delayed 3 cycles
    clear_stats();
    r_delay = 3; r_data_cfg = 32'h0000_0001; r_resp_cfg = 2'b00;
    exp_q.push_back({32'h0000_0001, 2'b00, 1'b0});
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    check("t3_arvalid_t1", {m_axi_arvalid, m_axi_awvalid}, 2'b10);
    check("t3_araddr", m_axi_araddr, 32'h0000_0008);
    wait_rsp(0, 1'b1);
    r_delay = 0;
    check("t3_rready_cycles", rready_hi, 4);
    check("t3_r_handshakes", r_hs, 1);
    check("t3_latency", first_rsp - acc_cyc, 6);

    // 3b: read returning DECERR does not set hung
    clear_stats();
    r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b11;
    exp_q.push_back({32'hDEAD_BEEF, 2'b11, 1'b0});
    issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp(0, 1'b1);
    check("t3b_latency", first_rsp - acc_cyc, 3);
    check("t3b_hung", hung, 0);
    r_resp_cfg = 2'b00;

    // 3c: write returning SLVERR passes through unmodified
    clear_stats();
    b_resp_cfg = 2'b10;
    exp_q.push_back({32'h0000_0000, 2'b10, 1'b0});
    issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h1);
    wait_rsp(0, 1'b1);
    check("t3c_hung", hung, 0);
    b_resp_cfg = 2'b00;

    // 5: rsp_ready held low for 10 cycles (stability checked by monitor)
    clear_stats();
    r_data_cfg = 32'h0BAD_F00D;
    exp_q.push_back({32'h0BAD_F00D, 2'b00, 1'b0});
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
    wait_rsp(10, 1'b1);
    check("t5_latency", first_rsp - acc_cyc, 3);

    // 6: reset while waiting in WR_B, then a normal read
    clear_stats();
    b_delay = 100;
    issue(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
    n = 0; saw = 1'b0;
    while (!saw && n < 10) begin
      @(negedge aclk);
      if (m_axi_bready) saw = 1'b1;
      n++;
    end
    check("t6_reached_wr_b", saw, 1);
    tick();
    areset = 1'b1;
    tick();
    check_reset_vals();
    areset = 1'b0;
    b_delay = 0;
    repeat (5) tick();
    check("t6_no_rsp_after_abort", rsp_seen, 0);
    clear_stats();
    r_data_cfg = 32'h0000_0077;
    exp_q.push_back({32'h0000_0077, 2'b00, 1'b0});
    issue(1'b0, 32'h0000_0044, 32'h0, 4'h0);
    wait_rsp(0, 1'b1);
    check("t6_latency", first_rsp - acc_cyc, 3);

    // 4: watchdog, arready never asserted
    clear_stats();
    ar_never = 1'b1;
    exp_q.push_back({32'h0000_0000, 2'b10, 1'b1});
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    wait_rsp(0, 1'b0);
    check("t4_ar_cycles", ar_hi, TO);
    check("t4_latency", first_rsp - acc_cyc, TO + 1);
    check("t4_hung", hung, 1);
    check("t4_state_hung", dbg_state, 3'd6);
    clear_stats();
    r_force = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0054;
    repeat (6) tick();
    cmd_valid = 1'b0;
    r_force = 1'b0;
    check("t4_no_accept_when_hung", cmd_acc, 0);
    check("t4_rready_stays_low", rready_hi, 0);
    check("t4_arvalid_stays_low", ar_hi, 0);
    check("t4_hung_sticky", hung, 1);
    ar_never = 1'b0;

    // recovery via reset
    areset = 1'b1;
    tick();
    check_reset_vals();
    areset = 1'b0;
    tick();
    clear_stats();
    r_data_cfg = 32'h0000_00AB;
    exp_q.push_back({32'h0000_00AB, 2'b00, 1'b0});
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(0, 1'b1);
    check("t7_latency", first_rsp - acc_cyc, 3);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
